// File: rtl/demo_synth_pkg.sv
// demo_synth_pkg: shared encodings, FSM states, LFSR constants and waveform helper for demo_audio_synth.
package demo_synth_pkg;
  typedef enum logic [1:0] {MODE_SQUARE, MODE_SAW, MODE_TRI, MODE_NOISE} mode_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  localparam logic [1:0] CFG_FREQ = 2'd0, CFG_MODEVOL = 2'd1, CFG_PHCLR = 2'd2;
  localparam logic [14:0] LFSR_SEED = 15'h7FFF, LFSR_TAPS = 15'h6000;
  // top holds the five phase MSBs; triangle folds on the MSB
  function automatic logic [3:0] wave_nibble(mode_t m, logic [4:0] top, logic [3:0] nz);
    return m == MODE_SQUARE ? {4{top[4]}} :
           m == MODE_SAW    ? top[4:1] :
           m == MODE_TRI    ? (top[4] ? ~top[3:0] : top[3:0]) : nz;
  endfunction
endpackage

// File: rtl/demo_synth_sigma_delta.sv
// demo_synth_sigma_delta: first-order sigma-delta, audio is the registered carry of sd + sample.
module demo_synth_sigma_delta #(
  parameter int MIX_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MIX_W-1:0] sample,
  output logic             audio
);
  logic [MIX_W-1:0] sd;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {audio, sd} <= '0;
    else {audio, sd} <= {1'b0, sd} + {1'b0, sample};
endmodule

// File: rtl/demo_audio_synth.sv
// demo_audio_synth: multi-voice phase-accumulator synth, time-multiplexed mixer, sigma-delta PDM out.
// Define DEMO_SYNTH_NOISE_EN to build the shared LFSR that feeds mode-3 voices.
module demo_audio_synth
  import demo_synth_pkg::*;
#(
  parameter int VOICES = 3,
  parameter int PHASE_W = 16,
  localparam int MIX_W = 8 + (VOICES > 1 ? $clog2(VOICES) : 0)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_tick,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_voice,
  input  logic [1:0]         cfg_addr,
  input  logic [PHASE_W-1:0] cfg_data,
  output logic [MIX_W-1:0]   sample,
  output logic               sample_valid,
  output logic               busy,
  output logic               audio
);
  localparam int IW = VOICES > 1 ? $clog2(VOICES) : 1;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [MIX_W-1:0] acc;
  logic [PHASE_W-1:0] freq [VOICES];
  logic [PHASE_W-1:0] phase [VOICES];
  mode_t mode [VOICES];
  logic [3:0] vol [VOICES];
  logic [PHASE_W-1:0] nxt_phase;
  logic [3:0] nz, w;
  logic [7:0] vout;
  logic last, run;
  assign run = state == S_RUN;
  assign last = idx == IW'(VOICES - 1);
  assign nxt_phase = phase[idx] + freq[idx];
  assign w = wave_nibble(mode[idx], phase[idx][PHASE_W-1 -: 5], nz);
  assign vout = {4'b0, w} * {4'b0, vol[idx]};
`ifdef DEMO_SYNTH_NOISE_EN
  logic [14:0] lfsr;
  logic [PHASE_W:0] wide_sum;
  assign wide_sum = {1'b0, phase[idx]} + {1'b0, freq[idx]};
  // advances only when a noise voice's accumulator wraps, so pitch sets the noise rate
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr <= LFSR_SEED;
    else if (run && mode[idx] == MODE_NOISE && wide_sum[PHASE_W]) lfsr <= {lfsr[13:0], ^(lfsr & LFSR_TAPS)};
  assign nz = lfsr[3:0];
`else
  assign nz = 4'd0;
`endif
  // phase clear is applied after the sequencer advance so it wins on collision
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int v = 0; v < VOICES; v++) begin
        freq[v] <= '0;
        phase[v] <= '0;
        mode[v] <= MODE_SQUARE;
        vol[v] <= '0;
      end
    end else begin
      for (int v = 0; v < VOICES; v++) begin
        if (run && idx == IW'(v)) phase[v] <= nxt_phase;
        if (cfg_we && cfg_voice == 3'(v)) begin
          if (cfg_addr == CFG_FREQ) freq[v] <= cfg_data;
          if (cfg_addr == CFG_MODEVOL) mode[v] <= mode_t'(cfg_data[5:4]);
          if (cfg_addr == CFG_MODEVOL) vol[v] <= cfg_data[3:0];
          if (cfg_addr == CFG_PHCLR) phase[v] <= '0;
        end
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == S_IDLE ? (sample_tick ? S_RUN : S_IDLE) :
               state == S_RUN  ? (last ? S_DONE : S_RUN) : S_IDLE;
  always_comb busy = state != S_IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      acc <= '0;
      sample <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= state == S_DONE;
      if (state == S_IDLE && sample_tick) begin
        idx <= '0;
        acc <= '0;
      end
      if (run) begin
        acc <= acc + MIX_W'(vout);
        idx <= last ? '0 : idx + 1'b1;
      end
      if (state == S_DONE) sample <= acc;
    end
  demo_synth_sigma_delta #(.MIX_W(MIX_W)) u_sd (
    .clk(clk),
    .rst_n(rst_n),
    .sample(sample),
    .audio(audio)
  );
endmodule

// File: tb/tb_demo_audio_synth.sv
// tb_demo_audio_synth: transaction-level model of the synth checked every cycle, plus directed literal checks.
module tb_demo_audio_synth;
  localparam int V = 3, PW = 16, MW = 10;
`ifdef DEMO_SYNTH_NOISE_EN
  localparam bit NOISE = 1'b1;
`else
  localparam bit NOISE = 1'b0;
`endif
  logic clk = 0, rst_n = 0, sample_tick = 0, cfg_we = 0;
  logic [2:0] cfg_voice = 0;
  logic [1:0] cfg_addr = 0;
  logic [PW-1:0] cfg_data = 0;
  logic [MW-1:0] sample;
  logic sample_valid, busy, audio;
  int n_vec = 0, n_err = 0;
  int m_freq [V], m_phase [V], m_mode [V], m_vol [V];
  int m_lfsr = 'h7FFF, rem = 0, pend = 0, e_sample = 0, e_valid = 0, e_audio = 0, m_sd = 0;

  demo_audio_synth #(.VOICES(V), .PHASE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .cfg_we(cfg_we),
    .cfg_voice(cfg_voice), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .sample(sample), .sample_valid(sample_valid), .busy(busy), .audio(audio)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // whole mix pass at once: every voice contributes from its current phase, then advances
  task automatic mix(output int s);
    s = 0;
    for (int v = 0; v < V; v++) begin
      int p, t, w;
      p = m_phase[v];
      t = (p >> (PW - 5)) % 16;
      w = m_mode[v] == 0 ? (p >= (1 << (PW - 1)) ? 15 : 0) :
          m_mode[v] == 1 ? p >> (PW - 4) :
          m_mode[v] == 2 ? (p >= (1 << (PW - 1)) ? 15 - t : t) :
          (NOISE ? m_lfsr % 16 : 0);
      s += w * m_vol[v];
      if (NOISE && m_mode[v] == 3 && p + m_freq[v] >= (1 << PW))
        m_lfsr = ((m_lfsr * 2) + (((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1)) % 32768;
      m_phase[v] = (p + m_freq[v]) % (1 << PW);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int v = 0; v < V; v++) begin
        m_freq[v] = 0; m_phase[v] = 0; m_mode[v] = 0; m_vol[v] = 0;
      end
      m_lfsr = 'h7FFF; rem = 0; pend = 0; e_sample = 0; e_valid = 0; e_audio = 0; m_sd = 0;
    end else begin
      m_sd += e_sample;
      e_audio = m_sd >= (1 << MW) ? 1 : 0;
      m_sd %= (1 << MW);
      e_valid = 0;
      if (cfg_we && int'(cfg_voice) < V) begin
        if (cfg_addr == 0) m_freq[cfg_voice] = int'(cfg_data);
        if (cfg_addr == 1) m_mode[cfg_voice] = (int'(cfg_data) >> 4) % 4;
        if (cfg_addr == 1) m_vol[cfg_voice] = int'(cfg_data) % 16;
        if (cfg_addr == 2) m_phase[cfg_voice] = 0;
      end
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin e_sample = pend; e_valid = 1; end
      end else if (sample_tick) begin
        mix(pend);
        rem = V + 1;
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("busy", int'(busy), rem > 0 ? 1 : 0);
      chk("sample_valid", int'(sample_valid), e_valid);
      chk("sample", int'(sample), e_sample);
      chk("audio", int'(audio), e_audio);
    end
  end

  task automatic wr(int v, int a, int d);
    cfg_we = 1; cfg_voice = 3'(v); cfg_addr = 2'(a); cfg_data = PW'(d);
    @(negedge clk);
    cfg_we = 0;
  endtask

  task automatic wait_valid(output int s);
    int n = 0;
    while (!sample_valid && n < V + 4) begin @(negedge clk); n++; end
    chk("pass_done", int'(sample_valid), 1);
    s = int'(sample);
  endtask

  task automatic run_pass(output int s);
    sample_tick = 1;
    @(negedge clk);
    sample_tick = 0;
    wait_valid(s);
  endtask

  // tick, then a config write landing on the edge where voice 0 is mixed
  task automatic pass_with_wr(int a, int d, output int s);
    sample_tick = 1;
    @(negedge clk);
    sample_tick = 0;
    cfg_we = 1; cfg_voice = 0; cfg_addr = 2'(a); cfg_data = PW'(d);
    @(negedge clk);
    cfg_we = 0;
    wait_valid(s);
  endtask

  initial begin
    int s, cnt, pos;
    int nz_exp [4] = '{15, 15, 14, 12};
    for (int k = 0; k < 5; k++) begin
      sample_tick = k[0];
      @(negedge clk);
      chk("reset_valid", int'(sample_valid), 0);
      chk("reset_sample", int'(sample), 0);
    end
    sample_tick = 0;
    rst_n = 1;
    @(negedge clk);
    wr(0, 0, 'h0000); wr(0, 1, 'h0F); wr(0, 2, 0); wr(0, 0, 'h8000);
    run_pass(s); chk("square_p0", s, 0);
    run_pass(s); chk("square_hi", s, 225);
    run_pass(s); chk("square_lo", s, 0);
    wr(0, 1, 'h11); wr(0, 0, 'h1000); wr(0, 2, 0);
    for (int k = 0; k <= 16; k++) begin
      run_pass(s);
      chk("saw_step", s, k % 16);
    end
    sample_tick = 1; @(negedge clk); sample_tick = 0;
    @(negedge clk); sample_tick = 1; @(negedge clk); sample_tick = 0;
    cnt = 0; pos = -1;
    for (int k = 3; k <= 12; k++) begin
      @(negedge clk);
      if (sample_valid) begin cnt++; pos = k; end
    end
    chk("drop_pulses", cnt, 1);
    chk("drop_pos", pos, V + 1);
    wr(0, 1, 'h0F); wr(0, 0, 'hC000); wr(0, 2, 0);
    run_pass(s); chk("clr_pre", s, 0);
    pass_with_wr(2, 0, s); chk("clr_cur", s, 225);
    run_pass(s); chk("clr_wins", s, 0);
    wr(0, 2, 0); wr(0, 0, 'h8000);
    run_pass(s); chk("fw_pre", s, 0);
    pass_with_wr(0, 'h4000, s); chk("fw_cur", s, 225);
    run_pass(s); chk("fw_oldfreq", s, 0);
    run_pass(s); chk("fw_newfreq", s, 0);
    run_pass(s); chk("fw_newfreq2", s, 225);
    wr(0, 1, 'h10); wr(0, 0, 'hC000); wr(0, 2, 0);
    wr(1, 1, 'h10); wr(1, 0, 'hC000); wr(1, 2, 0);
    wr(3, 1, 'h1F); wr(0, 3, 'h1234);
    run_pass(s); chk("duty_pre", s, 0);
    wr(0, 0, 0); wr(1, 0, 0); wr(0, 1, 'h1F); wr(1, 1, 'h11);
    run_pass(s); chk("duty_sample", s, 192);
    cnt = 0;
    repeat (1 << MW) begin @(negedge clk); cnt += int'(audio); end
    chk("duty_highs", cnt, 192);
    wr(1, 1, 0); wr(0, 1, 'h31); wr(0, 0, 'hFFFF); wr(0, 2, 0);
    for (int k = 0; k < 4; k++) begin
      run_pass(s);
      chk("noise_seq", s, NOISE ? nz_exp[k] : 0);
    end
    for (int k = 0; k < 8; k++) run_pass(s);
    sample_tick = 1; @(negedge clk); sample_tick = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_sample", int'(sample), 0);
    chk("abort_audio", int'(audio), 0);
    for (int k = 0; k < 6; k++) begin
      sample_tick = k[0];
      @(negedge clk);
      chk("abort_valid", int'(sample_valid), 0);
    end
    sample_tick = 0;
    rst_n = 1;
    for (int it = 0; it < 1500; it++) begin
      cfg_we = rem <= 1 && $urandom_range(0, 2) == 0;
      cfg_voice = 3'($urandom_range(0, 7) < 6 ? $urandom_range(0, V - 1) : $urandom_range(V, 7));
      cfg_addr = 2'($urandom_range(0, 3));
      cfg_data = $urandom_range(0, 1) ? PW'($urandom) : PW'($urandom_range(0, 'h1FFF));
      sample_tick = $urandom_range(0, 3) == 0;
      @(negedge clk);
    end
    cfg_we = 0;
    sample_tick = 0;
    repeat (V + 4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
